// File: rtl/dm_access_ctrl_if.sv
// Bundle of the request/response handshake and the data-memory port
// driven by dm_access_ctrl.
interface dm_access_ctrl_if;
  // Requester side
  logic        req;
  logic [2:0]  op;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] pc_in;
  logic        busy;
  logic        done;
  logic        err;
  logic [31:0] rdata;
  // Data-memory side
  logic        dm_we;
  logic [31:0] dm_a;
  logic [31:0] dm_wd;
  logic [31:0] dm_rd;
  logic [31:0] dm_pc;

  // Controller view
  modport slave (
    input  req, op, addr, wdata, pc_in, dm_rd,
    output busy, done, err, rdata, dm_we, dm_a, dm_wd, dm_pc
  );

  // Environment view (datapath plus memory)
  modport master (
    output req, op, addr, wdata, pc_in, dm_rd,
    input  busy, done, err, rdata, dm_we, dm_a, dm_wd, dm_pc
  );
endinterface

// File: rtl/dm_access_ctrl.sv
// Data-memory access controller: one load/store at a time, sub-word
// stores done as read-modify-write, sub-word loads extended.
// All outputs are registered so the DM address/data never glitch.
module dm_access_ctrl (
  input  logic           clk,
  input  logic           reset,
  dm_access_ctrl_if.slave bus
);

  localparam logic [2:0] OP_LW  = 3'b000;
  localparam logic [2:0] OP_LH  = 3'b001;
  localparam logic [2:0] OP_LHU = 3'b010;
  localparam logic [2:0] OP_LB  = 3'b011;
  localparam logic [2:0] OP_LBU = 3'b100;
  localparam logic [2:0] OP_SW  = 3'b101;
  localparam logic [2:0] OP_SH  = 3'b110;
  localparam logic [2:0] OP_SB  = 3'b111;

  typedef enum logic [1:0] {S_IDLE, S_RD, S_WR, S_DONE} state_t;

  state_t      r_state;
  logic [2:0]  r_op_q;
  logic [31:0] r_addr_q;
  logic [31:0] r_wdata_q;
  logic [31:0] r_pc_q;
  logic [31:0] r_word_q;
  logic        r_err_q;
  logic        r_busy;
  logic        r_done;
  logic        r_err;
  logic [31:0] r_rdata;
  logic        r_dm_we;
  logic [31:0] r_dm_a;
  logic [31:0] r_dm_wd;

  logic        w_misalign;
  logic        w_is_load_q;
  logic [15:0] w_half;
  logic [7:0]  w_byte;
  logic [31:0] w_load_ext;
  logic [31:0] w_merge_wd;

  // Alignment check on the incoming request (only meaningful in IDLE)
  always_comb begin
    w_misalign = 1'b0;
    case (bus.op)
      OP_LW, OP_SW:         w_misalign = (bus.addr[1:0] != 2'b00);
      OP_LH, OP_LHU, OP_SH: w_misalign = bus.addr[0];
      default:              w_misalign = 1'b0;
    endcase
  end

  assign w_is_load_q = (r_op_q == OP_LW) || (r_op_q == OP_LH) || (r_op_q == OP_LHU) ||
                       (r_op_q == OP_LB) || (r_op_q == OP_LBU);

  // Lane select and sign/zero extension of the word being read this cycle
  always_comb begin
    w_half = r_addr_q[1] ? bus.dm_rd[31:16] : bus.dm_rd[15:0];
    case (r_addr_q[1:0])
      2'd0:    w_byte = bus.dm_rd[7:0];
      2'd1:    w_byte = bus.dm_rd[15:8];
      2'd2:    w_byte = bus.dm_rd[23:16];
      default: w_byte = bus.dm_rd[31:24];
    endcase
    case (r_op_q)
      OP_LH:   w_load_ext = {{16{w_half[15]}}, w_half};
      OP_LHU:  w_load_ext = {16'h0000, w_half};
      OP_LB:   w_load_ext = {{24{w_byte[7]}}, w_byte};
      OP_LBU:  w_load_ext = {24'h000000, w_byte};
      default: w_load_ext = bus.dm_rd;
    endcase
  end

  // Merge store data into the word being read (little-endian lanes)
  always_comb begin
    w_merge_wd = bus.dm_rd;
    if (r_op_q == OP_SH) begin
      if (r_addr_q[1]) w_merge_wd[31:16] = r_wdata_q[15:0];
      else             w_merge_wd[15:0]  = r_wdata_q[15:0];
    end else begin
      case (r_addr_q[1:0])
        2'd0:    w_merge_wd[7:0]   = r_wdata_q[7:0];
        2'd1:    w_merge_wd[15:8]  = r_wdata_q[7:0];
        2'd2:    w_merge_wd[23:16] = r_wdata_q[7:0];
        default: w_merge_wd[31:24] = r_wdata_q[7:0];
      endcase
    end
  end

  // Access FSM; outputs are set for the state being entered
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= S_IDLE;
      r_op_q    <= 3'd0;
      r_addr_q  <= 32'd0;
      r_wdata_q <= 32'd0;
      r_pc_q    <= 32'd0;
      r_word_q  <= 32'd0;
      r_err_q   <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_err     <= 1'b0;
      r_rdata   <= 32'd0;
      r_dm_we   <= 1'b0;
      r_dm_a    <= 32'd0;
      r_dm_wd   <= 32'd0;
    end else begin
      r_done  <= 1'b0;
      r_err   <= 1'b0;
      r_dm_we <= 1'b0;
      r_dm_a  <= 32'd0;
      r_dm_wd <= 32'd0;
      case (r_state)
        S_IDLE: begin
          if (bus.req) begin
            r_op_q    <= bus.op;
            r_addr_q  <= bus.addr;
            r_wdata_q <= bus.wdata;
            r_pc_q    <= bus.pc_in;
            r_err_q   <= w_misalign;
            r_busy    <= 1'b1;
            if (w_misalign) begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
              r_err   <= 1'b1;
            end else if (bus.op == OP_SW) begin
              r_state <= S_WR;
              r_dm_we <= 1'b1;
              r_dm_a  <= {bus.addr[31:2], 2'b00};
              r_dm_wd <= bus.wdata;
            end else begin
              r_state <= S_RD;
              r_dm_a  <= {bus.addr[31:2], 2'b00};
            end
          end
        end
        S_RD: begin
          r_word_q <= bus.dm_rd;
          if (w_is_load_q) begin
            r_state <= S_DONE;
            r_done  <= 1'b1;
            r_rdata <= w_load_ext;
          end else begin
            r_state <= S_WR;
            r_dm_we <= 1'b1;
            r_dm_a  <= {r_addr_q[31:2], 2'b00};
            r_dm_wd <= w_merge_wd;
          end
        end
        S_WR: begin
          r_state <= S_DONE;
          r_done  <= 1'b1;
          r_err   <= r_err_q;
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy  = r_busy;
  assign bus.done  = r_done;
  assign bus.err   = r_err;
  assign bus.rdata = r_rdata;
  assign bus.dm_we = r_dm_we;
  assign bus.dm_a  = r_dm_a;
  assign bus.dm_wd = r_dm_wd;
  assign bus.dm_pc = r_pc_q;

endmodule

// File: tb/tb_dm_access_ctrl.sv
// Directed bench for dm_access_ctrl with a small word-addressed DM model.
module tb_dm_access_ctrl;

  localparam logic [2:0] OP_LW  = 3'b000;
  localparam logic [2:0] OP_LH  = 3'b001;
  localparam logic [2:0] OP_LHU = 3'b010;
  localparam logic [2:0] OP_LB  = 3'b011;
  localparam logic [2:0] OP_LBU = 3'b100;
  localparam logic [2:0] OP_SW  = 3'b101;
  localparam logic [2:0] OP_SH  = 3'b110;
  localparam logic [2:0] OP_SB  = 3'b111;

  logic clk;
  logic reset;
  int   vectors;
  int   miscompares;
  int   we_total;
  int   we_before;

  logic [31:0] mem [0:15];

  dm_access_ctrl_if bus ();

  dm_access_ctrl u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Combinational DM read, word write on the rising edge
  assign bus.dm_rd = mem[bus.dm_a[5:2]];
  always @(posedge clk) begin
    if (bus.dm_we) begin
      mem[bus.dm_a[5:2]] <= bus.dm_wd;
      we_total <= we_total + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Issue one request and follow it to done, then one cycle into IDLE
  task automatic run(input string tag, input logic [2:0] op_i, input logic [31:0] a,
                     input logic [31:0] wd, input logic [31:0] pc, input int exp_lat,
                     input logic exp_err, input logic [31:0] exp_rd,
                     input int exp_we, input logic [31:0] exp_wd);
    int          lat;
    int          wecnt;
    logic [31:0] seen_a;
    logic [31:0] seen_wd;
    logic        got;
    bus.req   = 1'b1;
    bus.op    = op_i;
    bus.addr  = a;
    bus.wdata = wd;
    bus.pc_in = pc;
    @(posedge clk); #1;
    bus.req   = 1'b0;
    lat = 1; wecnt = 0; seen_a = 32'd0; seen_wd = 32'd0; got = 1'b0;
    for (int k = 0; k < 8 && !got; k++) begin
      if (bus.dm_we) begin
        wecnt++;
        seen_a  = bus.dm_a;
        seen_wd = bus.dm_wd;
      end
      if (bus.done) got = 1'b1;
      else begin
        @(posedge clk); #1;
        lat++;
      end
    end
    chk({tag, " done"}, 32'(got), 32'd1);
    chk({tag, " latency"}, 32'(lat), 32'(exp_lat));
    chk({tag, " err"}, 32'(bus.err), 32'(exp_err));
    chk({tag, " busy"}, 32'(bus.busy), 32'd1);
    chk({tag, " dm_pc"}, bus.dm_pc, pc);
    chk({tag, " rdata"}, bus.rdata, exp_rd);
    chk({tag, " we count"}, 32'(wecnt), 32'(exp_we));
    if (exp_we > 0) begin
      chk({tag, " dm_a"}, seen_a, {a[31:2], 2'b00});
      chk({tag, " dm_wd"}, seen_wd, exp_wd);
    end
    @(posedge clk); #1;
    chk({tag, " idle busy"}, 32'(bus.busy), 32'd0);
    chk({tag, " idle done"}, 32'(bus.done), 32'd0);
    chk({tag, " idle dm_a"}, bus.dm_a, 32'd0);
    $display("txn %s op=%0d addr=%h wdata=%h lat=%0d err=%0b rdata=%h we=%0d",
             tag, op_i, a, wd, lat, bus.err, bus.rdata, wecnt);
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    we_total    = 0;
    for (int i = 0; i < 16; i++) mem[i] = 32'd0;
    bus.req   = 1'b0;
    bus.op    = 3'd0;
    bus.addr  = 32'd0;
    bus.wdata = 32'd0;
    bus.pc_in = 32'd0;
    reset     = 1'b0;

    // Reset state
    #3;
    chk("reset busy", 32'(bus.busy), 32'd0);
    chk("reset done", 32'(bus.done), 32'd0);
    chk("reset err", 32'(bus.err), 32'd0);
    chk("reset dm_we", 32'(bus.dm_we), 32'd0);
    chk("reset rdata", bus.rdata, 32'd0);
    chk("reset dm_a", bus.dm_a, 32'd0);
    chk("reset dm_wd", bus.dm_wd, 32'd0);
    chk("reset dm_pc", bus.dm_pc, 32'd0);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;

    // Word store and load
    run("sw 0x10", OP_SW, 32'h10, 32'h12345678, 32'h100, 2, 1'b0, 32'h0, 1, 32'h12345678);
    run("lw 0x10", OP_LW, 32'h10, 32'h0, 32'h104, 2, 1'b0, 32'h12345678, 0, 32'h0);

    // Byte store and loads
    run("sb 0x11", OP_SB, 32'h11, 32'h000000AB, 32'h108, 3, 1'b0, 32'h12345678, 1, 32'h1234AB78);
    run("lb 0x11", OP_LB, 32'h11, 32'h0, 32'h10C, 2, 1'b0, 32'hFFFFFFAB, 0, 32'h0);
    run("lbu 0x11", OP_LBU, 32'h11, 32'h0, 32'h110, 2, 1'b0, 32'h000000AB, 0, 32'h0);

    // Half store and loads
    run("sh 0x12", OP_SH, 32'h12, 32'h00008001, 32'h114, 3, 1'b0, 32'h000000AB, 1, 32'h8001AB78);
    run("lh 0x12", OP_LH, 32'h12, 32'h0, 32'h118, 2, 1'b0, 32'hFFFF8001, 0, 32'h0);
    run("lhu 0x12", OP_LHU, 32'h12, 32'h0, 32'h11C, 2, 1'b0, 32'h00008001, 0, 32'h0);
    run("lh 0x10", OP_LH, 32'h10, 32'h0, 32'h120, 2, 1'b0, 32'hFFFFAB78, 0, 32'h0);
    run("lb 0x13", OP_LB, 32'h13, 32'h0, 32'h124, 2, 1'b0, 32'hFFFFFF80, 0, 32'h0);
    run("lw 0x10 b", OP_LW, 32'h10, 32'h0, 32'h128, 2, 1'b0, 32'h8001AB78, 0, 32'h0);

    // Misaligned requests abort without writing, rdata held
    run("lw 0x13 mis", OP_LW, 32'h13, 32'h0, 32'h12C, 1, 1'b1, 32'h8001AB78, 0, 32'h0);
    run("sh 0x11 mis", OP_SH, 32'h11, 32'h0000FFFF, 32'h130, 1, 1'b1, 32'h8001AB78, 0, 32'h0);
    run("lw 0x10 c", OP_LW, 32'h10, 32'h0, 32'h134, 2, 1'b0, 32'h8001AB78, 0, 32'h0);

    // Reset during RD of a byte store
    bus.req   = 1'b1;
    bus.op    = OP_SB;
    bus.addr  = 32'h10;
    bus.wdata = 32'h000000CD;
    bus.pc_in = 32'h138;
    @(posedge clk); #1;
    bus.req   = 1'b0;
    chk("midrst in RD busy", 32'(bus.busy), 32'd1);
    we_before = we_total;
    reset = 1'b0;
    #1;
    chk("midrst busy", 32'(bus.busy), 32'd0);
    chk("midrst dm_we", 32'(bus.dm_we), 32'd0);
    chk("midrst dm_a", bus.dm_a, 32'd0);
    chk("midrst rdata", bus.rdata, 32'd0);
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      chk("midrst no done", 32'(bus.done), 32'd0);
      chk("midrst no we", 32'(bus.dm_we), 32'd0);
    end
    reset = 1'b1;
    @(posedge clk); #1;
    chk("midrst done after release", 32'(bus.done), 32'd0);
    chk("midrst write count", 32'(we_total), 32'(we_before));
    $display("txn reset-abort sb 0x10 writes=%0d", we_total - we_before);
    run("lw 0x10 d", OP_LW, 32'h10, 32'h0, 32'h13C, 2, 1'b0, 32'h8001AB78, 0, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/dm_access_ctrl.md
# dm_access_ctrl

Multi-cycle initiator that drives the word-wide data memory (DM) on behalf of the datapath. It accepts one load/store request at a time, handles word/half/byte sizes, and turns sub-word stores into a read-modify-write against DM's word-only write port. It sign/zero-extends sub-word loads and stalls the pipeline via `busy` until the access completes. It sits between the datapath's memory stage and DM, and owns DM's `WE`/`A`/`WD`/`pc` inputs and its `RD` output.

## Interface
- No parameters. Address and data are fixed at 32 bits.
- `clk` in 1: sole clock. All state updates on the rising edge.
- `reset` in 1: asynchronous, active-low. 0 forces the reset state immediately.
- `req` in 1: request valid. Sampled only in IDLE. The requester holds `op`/`addr`/`wdata`/`pc_in` stable in the accept cycle.
- `op` in 3: operation code.
  - 000 lw, 001 lh, 010 lhu, 011 lb, 100 lbu, 101 sw, 110 sh, 111 sb.
- `addr` in 32: byte address.
- `wdata` in 32: store data. Sub-word stores use the low bits.
- `pc_in` in 32: PC of the issuing instruction, forwarded to DM.
- `busy` out 1: high whenever state ≠ IDLE.
- `done` out 1: one-cycle completion pulse.
- `err` out 1: valid with `done`. High means the request was misaligned and aborted.
- `rdata` out 32: extended load result. Valid from `done` until the next accept.
- `dm_we` out 1: DM write enable.
- `dm_a` out 32: DM byte address, always word-aligned.
- `dm_wd` out 32: DM write data.
- `dm_rd` in 32: DM read data. Combinational from `dm_a`.
- `dm_pc` out 32: latched `pc_in`, for DM's write log.

## Operation
- States are IDLE, RD, WR, DONE.
- **IDLE, request accepted.** When `req`=1 at a rising edge, latch `op`, `addr`, `wdata`, `pc_in` into `*_q`. Then select the next state:
  - Misaligned request → DONE with the `err_q` flag set. A request is misaligned when:
    - lw/sw and `addr[1:0]`≠0, or
    - lh/lhu/sh and `addr[0]`≠0.
  - lw/lh/lhu/lb/lbu/sh/sb → RD.
  - sw → WR.
- **RD.**
  - Outputs: `dm_a`={`addr_q[31:2]`,2'b00}, `dm_we`=0.
  - At the edge, capture `dm_rd` into `word_q`.
  - Next state: loads → DONE; sh/sb → WR.
- **WR.**
  - Outputs: `dm_we`=1, `dm_a` as in RD. DM commits on this state's closing edge.
  - `dm_wd` by operation:
    - sw: `wdata_q`.
    - sh: `word_q` with half `addr_q[1]` (bits 16h+15:16h) replaced by `wdata_q[15:0]`.
    - sb: `word_q` with byte `addr_q[1:0]` (bits 8n+7:8n) replaced by `wdata_q[7:0]`.
  - Next state: DONE.
- **DONE.**
  - Outputs: `done`=1, `err`=`err_q`.
  - For loads, `rdata` is the selected lane of `word_q`. lh/lb sign-extend; lhu/lbu zero-extend; lw passes the word through.
  - `rdata` is registered when leaving RD and held until the next accept.
  - Stores and errors leave `rdata` unchanged.
  - Next state: IDLE. `req` seen in DONE is ignored; a new request is accepted from IDLE only.
- **Lane order** is little-endian: byte n occupies bits 8n+7:8n.
- **Outside RD/WR:** `dm_we`=0, `dm_a`=0, `dm_wd`=0.
- **`dm_pc`:** equals `pc_q` in all states.
- An erroring request never asserts `dm_we`.

## Timing
- **Reset values:** state IDLE; `busy`, `done`, `err`, `dm_we` = 0; `rdata`, `dm_a`, `dm_wd`, `dm_pc` and all `*_q` = 0.
- **Latency**, with accept edge e0 and counted in cycles after it:
  - lw/lh/lhu/lb/lbu: RD in cycle 1, `done` in cycle 2.
  - sw: WR in cycle 1, `done` in cycle 2.
  - sh/sb: RD in cycle 1, WR in cycle 2, `done` in cycle 3.
  - Misaligned: `done`+`err` in cycle 1.
- **Back-to-back:** the minimum issue interval is DONE→IDLE→accept. A second request is accepted one cycle after `done` at the earliest.
- **Exactly one write:** `dm_we` is high for exactly one cycle per successful store, and never for loads.
- **Reset mid-operation:** `reset`=0 during RD or WR drops `dm_we`/`busy` combinationally from the async state reset. No DM write occurs if reset lands before the WR closing edge. `done` is never issued for the aborted request.
- **Stable DM outputs:** `dm_a`/`dm_wd` are functions of registered state only, so they are glitch-free relative to `clk`.

## Test plan
- **Reset:** drive `reset`=0 for 3 cycles mid-run → all outputs 0 and `busy`=0 immediately. After release, the first accepted request behaves normally.
- **Word store/load:** sw `addr`=0x10, `wdata`=0x12345678, then lw 0x10.
  - sw: `dm_we` high in exactly 1 cycle with `dm_a`=0x10; `done` in cycle 2.
  - lw: `rdata`=0x12345678 with `done` in cycle 2.
- **Byte store/loads:** with word 0x10 = 0x12345678, sb 0x11 `wdata`=0x000000AB.
  - sb: `dm_wd`=0x1234AB78; `done` in cycle 3.
  - lb 0x11 → `rdata`=0xFFFFFFAB.
  - lbu 0x11 → `rdata`=0x000000AB.
- **Half store/loads:** sh 0x12 `wdata`=0x00008001 over 0x1234AB78.
  - sh: memory word becomes 0x8001AB78.
  - lh 0x12 → `rdata`=0xFFFF8001.
  - lhu 0x12 → `rdata`=0x00008001.
- **Misaligned:** lw 0x13 and sh 0x11 → each gives `done`=`err`=1 in cycle 1, `dm_we` never asserted, and word 0x10 is unchanged on readback.
- **Reset mid-store:** assert `reset`=0 during RD of sb 0x10 → no `dm_we` pulse and no `done`. Word 0x10 is unchanged on readback after release.
